// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : data_mem_arbiter_pkg
// Brief  : Shared state/owner encodings and defaults for the I/D memory arbiter.
// Rev    : 1.0
// ============================================================================
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  localparam int C_DEFAULT_TIMEOUT = 255;

  // A data request is any read or any nonzero byte-write mask.
  function automatic logic d_request(input logic i_re, input logic [3:0] i_we);
    return i_re | (|i_we);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module : mem_arb_watchdog
// Brief  : Counts enabled cycles; flags expiry on the limit-th cycle (limit 0 = never).
// Rev    : 1.0
// ============================================================================
module mem_arb_watchdog #(
  parameter int TO_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clear,
  input  logic            i_enable,
  input  logic [TO_W-1:0] i_limit,
  output logic            o_expired
);

  localparam logic [TO_W-1:0] C_ONE = TO_W'(1);

  logic [TO_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != {TO_W{1'b1}})) begin
      r_count <= r_count + C_ONE;
    end
  end

  // r_count holds the number of earlier enabled cycles, so expiry lands on cycle i_limit.
  assign o_expired = i_enable && (i_limit != '0) && (r_count == (i_limit - C_ONE));

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : data_mem_arbiter
// Brief  : Shares one word-addressed memory port between fetch (I) and data (D).
// Rev    : 1.0
// ============================================================================
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 30,
  parameter int TIMEOUT_CYCLES = C_DEFAULT_TIMEOUT,
  parameter int TO_W           = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] I_Address,
  input  logic              I_ReadEnable,
  output logic [31:0]       I_ReadData,
  output logic              I_Ready,
  output logic              I_Error,
  input  logic [ADDR_W-1:0] D_Address,
  input  logic              D_ReadEnable,
  input  logic [3:0]        D_WriteEnable,
  input  logic [31:0]       D_WriteData,
  output logic [31:0]       D_ReadData,
  output logic              D_Ready,
  output logic              D_Error,
  output logic [ADDR_W-1:0] M_Address,
  output logic              M_ReadEnable,
  output logic [3:0]        M_WriteEnable,
  output logic [31:0]       M_WriteData,
  input  logic [31:0]       M_ReadData,
  input  logic              M_Ready
);

  arb_state_t        r_state,  w_state_nxt;
  arb_owner_t        r_owner,  w_owner_nxt;
  arb_owner_t        r_last,   w_last_nxt;
  logic              r_flush,  w_flush_nxt;
  logic [ADDR_W-1:0] r_m_addr, w_m_addr_nxt;
  logic              r_m_re,   w_m_re_nxt;
  logic [3:0]        r_m_we,   w_m_we_nxt;
  logic [31:0]       r_m_wd,   w_m_wd_nxt;
  logic [31:0]       r_i_rdata, w_i_rdata_nxt, r_d_rdata, w_d_rdata_nxt;
  logic              r_i_rdy,  w_i_rdy_nxt,  r_d_rdy, w_d_rdy_nxt;
  logic              r_i_err,  w_i_err_nxt,  r_d_err, w_d_err_nxt;

  logic        w_i_req, w_d_req, w_grant_d, w_owner_req, w_flush_now;
  logic        w_wd_clear, w_wd_en, w_wd_expired;
  logic [31:0] w_cpl_data;

  assign w_i_req     = I_ReadEnable;
  assign w_d_req     = d_request(D_ReadEnable, D_WriteEnable);
  assign w_grant_d   = w_d_req && (!w_i_req || (r_last == OWN_I));
  assign w_owner_req = (r_owner == OWN_D) ? w_d_req : w_i_req;
  // A requester that lets go during BUSY has abandoned the access; its Ready is swallowed.
  assign w_flush_now = r_flush | ~w_owner_req;
  assign w_cpl_data  = (M_Ready && (r_m_we == 4'd0)) ? M_ReadData : 32'd0;

  mem_arb_watchdog #(
    .TO_W (TO_W)
  ) u_watchdog (
    .clk       (clock),
    .rst_n     (reset),
    .i_clear   (w_wd_clear),
    .i_enable  (w_wd_en),
    .i_limit   (TO_W'(TIMEOUT_CYCLES)),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ARB_IDLE;
      r_owner   <= OWN_I;
      r_last    <= OWN_I;
      r_flush   <= 1'b0;
      r_m_addr  <= '0;
      r_m_re    <= 1'b0;
      r_m_we    <= 4'd0;
      r_m_wd    <= 32'd0;
      r_i_rdata <= 32'd0;
      r_d_rdata <= 32'd0;
      r_i_rdy   <= 1'b0;
      r_d_rdy   <= 1'b0;
      r_i_err   <= 1'b0;
      r_d_err   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_last    <= w_last_nxt;
      r_flush   <= w_flush_nxt;
      r_m_addr  <= w_m_addr_nxt;
      r_m_re    <= w_m_re_nxt;
      r_m_we    <= w_m_we_nxt;
      r_m_wd    <= w_m_wd_nxt;
      r_i_rdata <= w_i_rdata_nxt;
      r_d_rdata <= w_d_rdata_nxt;
      r_i_rdy   <= w_i_rdy_nxt;
      r_d_rdy   <= w_d_rdy_nxt;
      r_i_err   <= w_i_err_nxt;
      r_d_err   <= w_d_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_last_nxt    = r_last;
    w_flush_nxt   = r_flush;
    w_m_addr_nxt  = r_m_addr;
    w_m_re_nxt    = r_m_re;
    w_m_we_nxt    = r_m_we;
    w_m_wd_nxt    = r_m_wd;
    w_i_rdata_nxt = r_i_rdata;
    w_d_rdata_nxt = r_d_rdata;
    w_i_rdy_nxt   = 1'b0;
    w_d_rdy_nxt   = 1'b0;
    w_i_err_nxt   = 1'b0;
    w_d_err_nxt   = 1'b0;
    w_wd_clear    = 1'b0;
    w_wd_en       = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_wd_clear = 1'b1;
        if (w_i_req || w_d_req) begin
          w_state_nxt = ARB_BUSY;
          w_flush_nxt = 1'b0;
          if (w_grant_d) begin
            w_owner_nxt  = OWN_D;
            w_last_nxt   = OWN_D;
            w_m_addr_nxt = D_Address;
            w_m_we_nxt   = D_WriteEnable;
            w_m_re_nxt   = (D_WriteEnable == 4'd0);
            w_m_wd_nxt   = D_WriteData;
          end else begin
            w_owner_nxt  = OWN_I;
            w_last_nxt   = OWN_I;
            w_m_addr_nxt = I_Address;
            w_m_we_nxt   = 4'd0;
            w_m_re_nxt   = 1'b1;
            w_m_wd_nxt   = 32'd0;
          end
        end
      end
      ARB_BUSY: begin
        w_wd_en     = 1'b1;
        w_flush_nxt = w_flush_now;
        if (M_Ready || w_wd_expired) begin
          w_state_nxt  = ARB_DONE;
          w_m_addr_nxt = '0;
          w_m_re_nxt   = 1'b0;
          w_m_we_nxt   = 4'd0;
          w_m_wd_nxt   = 32'd0;
          if (!w_flush_now) begin
            if (r_owner == OWN_D) begin
              w_d_rdy_nxt   = 1'b1;
              w_d_rdata_nxt = w_cpl_data;
              w_d_err_nxt   = ~M_Ready;
            end else begin
              w_i_rdy_nxt   = 1'b1;
              w_i_rdata_nxt = w_cpl_data;
              w_i_err_nxt   = ~M_Ready;
            end
          end
        end
      end
      ARB_DONE: w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  assign I_ReadData    = r_i_rdata;
  assign I_Ready       = r_i_rdy;
  assign I_Error       = r_i_err;
  assign D_ReadData    = r_d_rdata;
  assign D_Ready       = r_d_rdy;
  assign D_Error       = r_d_err;
  assign M_Address     = r_m_addr;
  assign M_ReadEnable  = r_m_re;
  assign M_WriteEnable = r_m_we;
  assign M_WriteData   = r_m_wd;

endmodule
`default_nettype wire
